// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
//
// Pipeline latch controller for a five-stage core. It takes the hazard unit's
// decisions (lw_nop, jmp_flush, brch_flush), the cache handshakes (ihit, dhit)
// and the retiring halt. From these it drives the PC enable, and an enable and
// a flush for each pipeline latch. It also keeps a data-memory wait watchdog and
// a sticky halt state.
//
// Optional feature macro: PIPELINE_PERF_EN
//   When defined, the stall_cycles and flush_count performance counter ports
//   are present. When undefined, both ports and both counters are absent.
//
// Parameters:
//   TIMEOUT      consecutive MEMWAIT cycles after which mem_timeout sets
//
// Ports:
//   CLK          clock, rising edge
//   nRST         asynchronous active-low reset
//   ihit         instruction cache hit for the current PC
//   dhit         data cache completed the EX/MEM access
//   exmem_dren   EX/MEM holds a load (atomics included)
//   exmem_dwen   EX/MEM holds a store (atomics included)
//   lw_nop       load-use stall request from the hazard unit
//   jmp_flush    jump redirect resolved in EX
//   brch_flush   branch redirect resolved in EX
//   memwb_halt   halt instruction is in MEM/WB
//   pc_en        PC register loads the next PC
//   ifid_en      IF/ID latch advance enable
//   idex_en      ID/EX latch advance enable
//   exmem_en     EX/MEM latch advance enable
//   memwb_en     MEM/WB latch advance enable
//   ifid_flush   IF/ID loads a bubble instead of its input
//   idex_flush   ID/EX loads a bubble instead of its input
//   dmem_busy    controller is waiting on data memory (state MEMWAIT)
//   halted       sticky halt (state HALTED)
//   mem_timeout  sticky watchdog flag
//   fsm_state    debug view of the controller state (RUN=0, MEMWAIT=1, HALTED=2)
//   stall_cycles cycles with pc_en low while not halted (PIPELINE_PERF_EN only)
//   flush_count  cycles in which a control redirect was taken (PIPELINE_PERF_EN only)
//
// Handshake semantics: ihit and dhit act as "ready" for the current fetch and
// for the EX/MEM data access. The data request is "valid" while exmem_dren or
// exmem_dwen is high. The access completes in the cycle where both valid and
// dhit are high. Valid without dhit freezes the whole pipeline.
// -----------------------------------------------------------------------------
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        exmem_dren,
  input  logic        exmem_dwen,
  input  logic        lw_nop,
  input  logic        jmp_flush,
  input  logic        brch_flush,
  input  logic        memwb_halt,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        dmem_busy,
  output logic        halted,
  output logic        mem_timeout,
  output logic [1:0]  fsm_state
`ifdef PIPELINE_PERF_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  // The watchdog counter only needs to reach TIMEOUT, where it saturates.
  localparam int unsigned WCNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT);

  state_t            state;
  state_t            state_next;
  logic              dreq;
  logic              freeze;
  logic              redirect;
  logic              redirect_fire;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_inc;

  assign dreq     = exmem_dren | exmem_dwen;
  assign freeze   = dreq & ~dhit;
  assign redirect = jmp_flush | brch_flush;
  assign wcnt_inc = wcnt + 1'b1;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A halt reaching MEM/WB wins from any state, and only
  // reset leaves HALTED.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (memwb_halt) begin
          state_next = ST_HALTED;
        end else if (freeze) begin
          state_next = ST_MEMWAIT;
        end
      end
      ST_MEMWAIT: begin
        if (memwb_halt) begin
          state_next = ST_HALTED;
        end else if (dhit) begin
          state_next = ST_RUN;
        end
      end
      ST_HALTED: begin
        state_next = ST_HALTED;
      end
      default: begin
        state_next = ST_RUN;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Latch enables and flushes. These are a priority decode and the first
  // matching rule wins. In MEMWAIT, freeze is low in the dhit cycle, so
  // writeback advances through the lower rules in that same cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en         = 1'b0;
    ifid_en       = 1'b0;
    idex_en       = 1'b0;
    exmem_en      = 1'b0;
    memwb_en      = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    redirect_fire = 1'b0;
    if ((state == ST_HALTED) || memwb_halt) begin
      // Pipeline frozen: halt is retiring or has retired.
    end else if (freeze) begin
      // The data access is outstanding, so nothing moves.
    end else if (redirect) begin
      // A redirect does not need ihit. The wrong-path fetch is squashed by the
      // IF/ID flush, so a missed fetch is simply discarded.
      pc_en         = 1'b1;
      ifid_en       = 1'b1;
      idex_en       = 1'b1;
      exmem_en      = 1'b1;
      memwb_en      = 1'b1;
      ifid_flush    = 1'b1;
      idex_flush    = 1'b1;
      redirect_fire = 1'b1;
    end else if (lw_nop || !ihit) begin
      // Hold PC and IF/ID. A bubble goes into ID/EX and the back end drains.
      idex_en    = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Data-memory watchdog. The counter advances on every MEMWAIT cycle that
  // stays in MEMWAIT, and saturates at TIMEOUT. mem_timeout is set on the edge
  // where the count reaches TIMEOUT and stays set until reset. The counter
  // clears whenever the controller heads back to RUN.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wcnt        <= '0;
      mem_timeout <= 1'b0;
    end else begin
      if ((state == ST_MEMWAIT) && (state_next == ST_MEMWAIT)) begin
        if (wcnt != WCNT_MAX) begin
          wcnt <= wcnt_inc;
          if (wcnt_inc == WCNT_MAX) begin
            mem_timeout <= 1'b1;
          end
        end
      end else if (state_next == ST_RUN) begin
        wcnt <= '0;
      end
    end
  end

`ifdef PIPELINE_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters. Both wrap modulo 2^32.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (!pc_en && (state != ST_HALTED)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (redirect_fire) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

  // Status outputs decode the registered state directly.
  assign dmem_busy = (state == ST_MEMWAIT);
  assign halted    = (state == ST_HALTED);
  assign fsm_state = state;

  // A latch may only flush when it is also enabled.
  a_ifid_flush_en : assert property (@(posedge CLK) disable iff (!nRST)
    ifid_flush |-> ifid_en);
  a_idex_flush_en : assert property (@(posedge CLK) disable iff (!nRST)
    idex_flush |-> idex_en);

endmodule

// File: tb/tb_pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_ctrl
//
// Directed bench for pipeline_ctrl with TIMEOUT=8. Inputs change 1 ns after
// the rising edge. Outputs are sampled a further 1 ns later, well away from
// the next edge. The enable/flush bundle is compared as
// {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush}.
// -----------------------------------------------------------------------------
module tb_pipeline_ctrl;

  localparam logic [6:0] EN_NONE  = 7'b00000_00;
  localparam logic [6:0] EN_RUN   = 7'b11111_00;
  localparam logic [6:0] EN_REDIR = 7'b11111_11;
  localparam logic [6:0] EN_BUBL  = 7'b00111_01;

  logic        CLK;
  logic        nRST;
  logic        ihit, dhit, exmem_dren, exmem_dwen;
  logic        lw_nop, jmp_flush, brch_flush, memwb_halt;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush;
  logic        dmem_busy, halted, mem_timeout;
  logic [1:0]  fsm_state;
`ifdef PIPELINE_PERF_EN
  logic [31:0] stall_cycles, flush_count;
`endif
  logic [6:0]  en_vec;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_ctrl #(.TIMEOUT(8)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .ihit        (ihit),
    .dhit        (dhit),
    .exmem_dren  (exmem_dren),
    .exmem_dwen  (exmem_dwen),
    .lw_nop      (lw_nop),
    .jmp_flush   (jmp_flush),
    .brch_flush  (brch_flush),
    .memwb_halt  (memwb_halt),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .idex_en     (idex_en),
    .exmem_en    (exmem_en),
    .memwb_en    (memwb_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .dmem_busy   (dmem_busy),
    .halted      (halted),
    .mem_timeout (mem_timeout),
    .fsm_state   (fsm_state)
`ifdef PIPELINE_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
`endif
  );

  assign en_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

  // Clock / reset block
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Checker
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic drive(input logic i_ihit, input logic i_dhit, input logic i_dren,
                       input logic i_dwen, input logic i_lw, input logic i_jmp,
                       input logic i_brch, input logic i_halt);
    ihit       = i_ihit;
    dhit       = i_dhit;
    exmem_dren = i_dren;
    exmem_dwen = i_dwen;
    lw_nop     = i_lw;
    jmp_flush  = i_jmp;
    brch_flush = i_brch;
    memwb_halt = i_halt;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Stimulus
  initial begin
    nRST = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    check_val("rst_busy",    {31'd0, dmem_busy},   32'd0);
    check_val("rst_halted",  {31'd0, halted},      32'd0);
    check_val("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    check_val("rst_state",   {30'd0, fsm_state},   32'd0);
`ifdef PIPELINE_PERF_EN
    check_val("rst_stall",   stall_cycles,         32'd0);
    check_val("rst_flush",   flush_count,          32'd0);
`endif
    #10;
    @(negedge CLK);
    nRST = 1'b1;

    next_cycle();
    #1 check_val("run_en", {25'd0, en_vec}, {25'd0, EN_RUN});

    // Load miss for three cycles, then dhit.
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    #1 check_val("miss1_en",   {25'd0, en_vec}, {25'd0, EN_NONE});
    check_val("miss1_busy",    {31'd0, dmem_busy}, 32'd0);
    next_cycle();
    #1 check_val("miss2_en",   {25'd0, en_vec}, {25'd0, EN_NONE});
    check_val("miss2_busy",    {31'd0, dmem_busy}, 32'd1);
    next_cycle();
    #1 check_val("miss3_en",   {25'd0, en_vec}, {25'd0, EN_NONE});
    check_val("miss3_busy",    {31'd0, dmem_busy}, 32'd1);
    next_cycle();
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    #1 check_val("dhit_en",    {25'd0, en_vec}, {25'd0, EN_RUN});
    check_val("dhit_busy",     {31'd0, dmem_busy}, 32'd1);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 check_val("post_busy",  {31'd0, dmem_busy}, 32'd0);
    check_val("post_state",    {30'd0, fsm_state}, 32'd0);
    check_val("post_en",       {25'd0, en_vec}, {25'd0, EN_RUN});

    // Load-use stall.
    next_cycle();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    #1 check_val("lw_en", {25'd0, en_vec}, {25'd0, EN_BUBL});

    // Freeze beats lw_nop; once dhit arrives the stall applies.
    next_cycle();
    drive(1, 0, 0, 1, 1, 0, 0, 0);
    #1 check_val("frz_lw_en", {25'd0, en_vec}, {25'd0, EN_NONE});
    drive(1, 1, 0, 1, 1, 0, 0, 0);
    #1 check_val("dhit_lw_en", {25'd0, en_vec}, {25'd0, EN_BUBL});

    // Instruction miss.
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check_val("imiss_en", {25'd0, en_vec}, {25'd0, EN_BUBL});

    // Branch with ihit=0 and a completing load.
    next_cycle();
    drive(0, 1, 1, 0, 0, 0, 1, 0);
    #1 check_val("brch_en", {25'd0, en_vec}, {25'd0, EN_REDIR});

    // Jump beats lw_nop.
    next_cycle();
    drive(1, 0, 0, 0, 1, 1, 0, 0);
    #1 check_val("jmp_lw_en", {25'd0, en_vec}, {25'd0, EN_REDIR});

    // Freeze beats a branch until dhit arrives.
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 1, 0);
    #1 check_val("frz_brch_en", {25'd0, en_vec}, {25'd0, EN_NONE});
    drive(1, 1, 1, 0, 0, 0, 1, 0);
    #1 check_val("dhit_brch_en", {25'd0, en_vec}, {25'd0, EN_REDIR});

    // Watchdog with TIMEOUT=8. The freeze cycle enters MEMWAIT.
    next_cycle();
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      next_cycle();
      #1;
      if (k == 8) begin
        check_val("wd8_timeout", {31'd0, mem_timeout}, 32'd0);
        check_val("wd8_busy",    {31'd0, dmem_busy},   32'd1);
      end
      if (k == 9) begin
        check_val("wd9_timeout", {31'd0, mem_timeout}, 32'd1);
      end
    end
    next_cycle();
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    #1 check_val("wd_dhit_en", {25'd0, en_vec}, {25'd0, EN_RUN});
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 check_val("wd_sticky", {31'd0, mem_timeout}, 32'd1);
    check_val("wd_busy",      {31'd0, dmem_busy},   32'd0);
    #1 nRST = 1'b0;
    #1 check_val("wd_async_clr", {31'd0, mem_timeout}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Reset asserted during MEMWAIT.
    next_cycle();
    drive(1, 0, 0, 1, 0, 0, 0, 0);
    next_cycle();
    #1 check_val("mw_busy", {31'd0, dmem_busy}, 32'd1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    #1 check_val("mw_rst_busy", {31'd0, dmem_busy}, 32'd0);
    check_val("mw_rst_state",   {30'd0, fsm_state}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Counter-defined sequence followed by a halt pulse.
    next_cycle();
    drive(1, 0, 0, 0, 1, 0, 0, 0);
    next_cycle();
    next_cycle();
    drive(1, 1, 0, 0, 0, 0, 1, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    #1 check_val("halt_en",    {25'd0, en_vec}, {25'd0, EN_NONE});
    check_val("halt_pre",      {31'd0, halted}, 32'd0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 1, 0);
    #1 check_val("halted1",    {31'd0, halted},    32'd1);
    check_val("halted1_en",    {25'd0, en_vec},    {25'd0, EN_NONE});
    check_val("halted1_state", {30'd0, fsm_state}, 32'd2);
    next_cycle();
    drive(1, 1, 1, 0, 0, 0, 0, 0);
    #1 check_val("halted2_en",   {25'd0, en_vec},    {25'd0, EN_NONE});
    check_val("halted2_busy",    {31'd0, dmem_busy}, 32'd0);
    next_cycle();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 check_val("halted3",      {31'd0, halted},    32'd1);
    check_val("halted3_en",      {25'd0, en_vec},    {25'd0, EN_NONE});
`ifdef PIPELINE_PERF_EN
    check_val("perf_stall", stall_cycles, 32'd3);
    check_val("perf_flush", flush_count,  32'd1);
`endif
    nRST = 1'b0;
    #1 check_val("halt_rst", {31'd0, halted}, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    next_cycle();
    #1 check_val("final_en", {25'd0, en_vec}, {25'd0, EN_RUN});

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
